mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  load/store request present.
REQ-005 req_ready  out  1  controller can accept a request; equals (state==IDLE) and rst_n high.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 req_unsigned  in  1  loads only: 1=zero-extend (LBU/LHU), 0=sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned or illegal-size request; valid with resp_valid.
REQ-014 mem_we  out  2  to data RAM: [0]=write enable, [1]=byte mode (lane from mem_addr[1:0], data from mem_wdata[7:0]).
REQ-015 mem_addr  out  32  RAM byte address.
REQ-016 mem_wdata  out  32  RAM write data.
REQ-017 mem_rdata  in  32  RAM read data, valid the cycle after the address edge (registered read address).

Function
REQ-018 States SHALL be IDLE, ST_B0, ST_B1, LD, LD_W, RESP; exactly one request in flight.
REQ-019 IDLE: on req_valid&req_ready, latch write/size/unsigned/addr/wdata; next = RESP(err) if size=11, half with addr[0]=1, or word with addr[1:0]!=0; else ST_B0 for store, LD for load.
REQ-020 ST_B0: mem_addr=latched addr; word -> mem_we=01, mem_wdata=wdata; byte/half -> mem_we=11, mem_wdata={24'h0,wdata[7:0]}; next = ST_B1 if half, else RESP.
REQ-021 ST_B1: mem_addr=latched addr+1, mem_we=11, mem_wdata={24'h0,wdata[15:8]}; next = RESP (no carry beyond bit 1 since addr[0]=0).
REQ-022 LD: mem_addr=latched addr, mem_we=00; next = LD_W.
REQ-023 LD_W: capture mem_rdata; byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16], word = rdata; extend per unsigned flag into resp_rdata register; next = RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle, resp_err/resp_rdata held from registers; next = IDLE; req_ready=0 in RESP.
REQ-025 mem_we SHALL be 00 in every state except ST_B0/ST_B1; mem_addr holds latched addr in IDLE/RESP.
REQ-026 Latency from accept edge T: error resp at T+1; SB/SW resp at T+2; SH resp at T+3; loads resp at T+3.
REQ-027 Errored requests SHALL cause no RAM write; req_valid while req_ready=0 SHALL be ignored (not queued).
REQ-028 Back-to-back: a new request is accepted the cycle after RESP (IDLE), never in RESP.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=00, mem_addr=0, mem_wdata=0, all latches 0.
REQ-030 Reset mid-operation SHALL abort: in-progress SH may leave only the low byte written; no response is emitted for the aborted request.
REQ-031 First acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one write cycle mem_we=01; load resp at T+3 rdata=0xDEADBEEF, err=0.
REQ-033 SH addr 0x22 data 0x0000A55A -> mem_we=11 at 0x22 data 0x5A, then 0x23 data 0xA5; LH 0x22 -> 0xFFFFA55A, LHU 0x22 -> 0x0000A55A.
REQ-034 SB addr 0x13 data 0x80 over word 0xDEADBEEF at 0x10; LW 0x10 -> 0x80ADBEEF; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
REQ-035 LW addr 0x11, SH addr 0x21, req_size=11 -> resp at T+1 err=1 rdata=0, mem_we stays 00, memory unchanged.
REQ-036 Assert rst_n low during ST_B1 of SH -> all outputs at reset values same cycle, no resp_valid; next request after release completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl.
// Carries the load/store request handshake, the one-cycle response and the
// data-RAM port. The slave modport is the controller's view; the master
// modport is the view of whatever sits on the other side (requester and RAM).
//   req_valid/req_ready   request handshake
//   req_write/size/unsigned/addr/wdata   request payload
//   resp_valid/rdata/err  completion pulse and result
//   mem_we/addr/wdata/rdata  byte-addressed RAM with registered read address
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store unit in front of a data RAM
// that writes either a full word or a single byte per cycle.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         mem_access_ctrl_if.slave (request, response, RAM port)
// Stores of a halfword are split into two byte writes; loads are
// extracted from the returned word and sign/zero-extended. Misaligned or
// illegal-size requests answer one cycle after acceptance with resp_err set
// and never touch the RAM.
module mem_access_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ST_B0 = 3'd1;
    localparam logic [2:0] ST_B1 = 3'd2;
    localparam logic [2:0] LD    = 3'd3;
    localparam logic [2:0] LD_W  = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q,  size_d;
    logic        uns_q,   uns_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic        accept;
    logic        req_bad;
    logic [31:0] byte_sel;
    logic [31:0] half_sel;

    assign bus.req_ready  = (state_q == IDLE) && rst_n;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            SZ_HALF: req_bad = bus.req_addr[0];
            SZ_WORD: req_bad = (bus.req_addr[1:0] != 2'b00);
            SZ_ILL:  req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Lane selection for loads: shift the addressed byte/half down to bit 0.
    assign byte_sel = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel = bus.mem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = RESP;
                    else if (bus.req_write)
                        state_d = ST_B0;
                    else
                        state_d = LD;
                end
            end
            ST_B0:   state_d = (size_q == SZ_HALF) ? ST_B1 : RESP;
            ST_B1:   state_d = RESP;
            LD:      state_d = LD_W;
            LD_W: begin
                case (size_q)
                    SZ_BYTE: rdata_d = uns_q ? {24'h0, byte_sel[7:0]}
                                             : {{24{byte_sel[7]}}, byte_sel[7:0]};
                    SZ_HALF: rdata_d = uns_q ? {16'h0, half_sel[15:0]}
                                             : {{16{half_sel[15]}}, half_sel[15:0]};
                    default: rdata_d = bus.mem_rdata;
                endcase
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port is decoded from the current state so that reset clears it
    // in the same cycle it is asserted.
    always_comb begin
        bus.mem_we    = 2'b00;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = '0;
        case (state_q)
            ST_B0: begin
                if (size_q == SZ_WORD) begin
                    bus.mem_we    = 2'b01;
                    bus.mem_wdata = wdata_q;
                end else begin
                    bus.mem_we    = 2'b11;
                    bus.mem_wdata = {24'h0, wdata_q[7:0]};
                end
            end
            ST_B1: begin
                // Halfword is even-aligned here, so +1 only sets bit 0.
                bus.mem_addr  = {addr_q[31:1], 1'b1};
                bus.mem_we    = 2'b11;
                bus.mem_wdata = {24'h0, wdata_q[15:8]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte-lane RAM model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: 64 words, word or single-byte writes, registered read address.
    logic [31:0] mem [0:63] = '{default: '0};
    logic [5:0]  rd_q = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (bus.mem_we[0]) begin
            if (bus.mem_we[1])
                mem[bus.mem_addr[7:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
            else
                mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        rd_q <= bus.mem_addr[7:2];
    end

    assign bus.mem_rdata = mem[rd_q];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid    = v;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    // Issue one request, measure latency from the accept edge, check result.
    task automatic do_req(input string nm, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_e, input logic [31:0] exp_rd,
                          input int exp_lat, input int exp_wr);
        int lat;
        int w0;
        logic got_e;
        logic [31:0] got_rd;
        @(negedge clk);
        drive(1'b1, w, sz, u, a, wd);
        w0 = wr_cnt;
        chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_e  = bus.resp_err;
        got_rd = bus.resp_rdata;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " err"}, 32'(got_e), 32'(exp_e));
        chk({nm, " rdata"}, got_rd, exp_rd);
        chk({nm, " writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
        @(posedge clk);
        #1;
        chk({nm, " pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e;
        logic [31:0] rd;
        int          lat;
        int          wr;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{"SW 10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2, 1};
        vt[1]  = '{"LW 10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3, 0};
        vt[2]  = '{"SH 22",   1'b1, 2'b01, 1'b0, 32'h22, 32'h0000A55A, 1'b0, 32'h0,        3, 2};
        vt[3]  = '{"LH 22",   1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        1'b0, 32'hFFFFA55A, 3, 0};
        vt[4]  = '{"LHU 22",  1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        1'b0, 32'h0000A55A, 3, 0};
        vt[5]  = '{"SB 13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 1'b0, 32'h0,        2, 1};
        vt[6]  = '{"LW 10b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h80ADBEEF, 3, 0};
        vt[7]  = '{"LB 13",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, 3, 0};
        vt[8]  = '{"LBU 13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b0, 32'h00000080, 3, 0};
        vt[9]  = '{"LW 11",   1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        1'b1, 32'h0,        1, 0};
        vt[10] = '{"SH 21",   1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, 1'b1, 32'h0,        1, 0};
        vt[11] = '{"SZ3 10",  1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 1'b1, 32'h0,        1, 0};
        vt[12] = '{"LW 10c",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h80ADBEEF, 3, 0};
        vt[13] = '{"LW 20",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b0, 32'hA55A0000, 3, 0};
        vt[14] = '{"LB 22",   1'b0, 2'b00, 1'b0, 32'h22, 32'h0,        1'b0, 32'h0000005A, 3, 0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #12;
        chk("rst ready",  32'(bus.req_ready),  32'd0);
        chk("rst valid",  32'(bus.resp_valid), 32'd0);
        chk("rst rdata",  bus.resp_rdata,      32'h0);
        chk("rst err",    32'(bus.resp_err),   32'd0);
        chk("rst we",     32'(bus.mem_we),     32'd0);
        chk("rst addr",   bus.mem_addr,        32'h0);
        chk("rst wdata",  bus.mem_wdata,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            do_req(vt[i].nm, vt[i].w, vt[i].sz, vt[i].u, vt[i].a, vt[i].wd,
                   vt[i].e, vt[i].rd, vt[i].lat, vt[i].wr);
        chk("err mem unchanged", mem[4], 32'h80ADBEEF);
        chk("err mem 20",        mem[8], 32'hA55A0000);

        // Request presented while busy must be dropped, not queued.
        begin
            int w0;
            @(negedge clk);
            drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111);
            w0 = wr_cnt;
            @(posedge clk);
            #1;
            drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h34, 32'h22222222);
            @(posedge clk);
            #1;
            chk("busy resp", 32'(bus.resp_valid), 32'd1);
            chk("busy ready in RESP", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("busy idle ready", 32'(bus.req_ready), 32'd1);
            chk("busy no resp", 32'(bus.resp_valid), 32'd0);
            chk("busy writes", 32'(wr_cnt - w0), 32'd1);
            chk("busy mem 30", mem[12], 32'h11111111);
            chk("busy mem 34", mem[13], 32'h0);
        end

        // Reset during the second byte of a halfword store.
        begin
            int n_resp;
            @(negedge clk);
            drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h28, 32'h0000BBAA);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("sh b1 we",   32'(bus.mem_we), 32'd3);
            chk("sh b1 addr", bus.mem_addr,    32'h29);
            rst_n = 1'b0;
            #1;
            chk("abort we",    32'(bus.mem_we),     32'd0);
            chk("abort addr",  bus.mem_addr,        32'h0);
            chk("abort wdata", bus.mem_wdata,       32'h0);
            chk("abort valid", 32'(bus.resp_valid), 32'd0);
            chk("abort ready", 32'(bus.req_ready),  32'd0);
            n_resp = 0;
            repeat (2) begin
                @(posedge clk);
                #1;
                if (bus.resp_valid) n_resp++;
            end
            chk("abort no resp", 32'(n_resp), 32'd0);
            chk("abort low byte only", mem[10], 32'h000000AA);
            #1;
            rst_n = 1'b1;
        end
        do_req("LHU after rst", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000A55A, 3, 0);
        do_req("SW after rst",  1'b1, 2'b10, 1'b0, 32'h28, 32'h01020304, 1'b0, 32'h0, 2, 1);
        chk("SW after rst mem", mem[10], 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
